// File: rtl/ram_port_arbiter_if.sv
// Bundles the requester handshakes, clear control and MultiRAM port signals
// of the RAM port arbiter.
//   master : requesters plus RAM controller side (drives req/fields, ram_dout)
//   slave  : the arbiter (drives grants, read valid/data, ram_* outputs)
interface ram_port_arbiter_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;

  // requester A: display fetch reads
  logic              req_a;
  logic [SEL_W-1:0]  sel_a;
  logic [ADDR_W-1:0] menu_a;
  logic [ADDR_W-1:0] add_a;
  logic              gnt_a;
  logic              rvalid_a;
  logic [DATA_W-1:0] rdata_a;

  // requester B: local-RAM edit writes
  logic              req_b;
  logic [ADDR_W-1:0] add_b;
  logic [DATA_W-1:0] din_b;
  logic              gnt_b;

  // clear sequencer control
  logic              clear_req;
  logic              clear_done;
  logic              busy;

  // MultiRAM port
  logic [SEL_W-1:0]  ram_sel;
  logic [ADDR_W-1:0] ram_menu;
  logic [ADDR_W-1:0] ram_add;
  logic [DATA_W-1:0] ram_din;
  logic              ram_w;
  logic              ram_clear;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    output req_a, sel_a, menu_a, add_a, req_b, add_b, din_b, clear_req, ram_dout,
    input  gnt_a, rvalid_a, rdata_a, gnt_b, clear_done, busy,
           ram_sel, ram_menu, ram_add, ram_din, ram_w, ram_clear
  );

  modport slave (
    input  req_a, sel_a, menu_a, add_a, req_b, add_b, din_b, clear_req, ram_dout,
    output gnt_a, rvalid_a, rdata_a, gnt_b, clear_done, busy,
           ram_sel, ram_menu, ram_add, ram_din, ram_w, ram_clear
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single MultiRAM port between the display fetch path (A, reads),
// the local-RAM edit path (B, writes) and a serial local-RAM clear sequencer.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - ram_port_arbiter_if.slave: request/grant handshakes, clear
//          control, and the registered MultiRAM_* outputs / ram_dout input
module ram_port_arbiter #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter logic [1:0] SEL_LOCAL  = 2'd2
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(31);
  localparam logic [ADDR_W-1:0] PENULT_ADDR = ADDR_W'(30);

  typedef enum logic [0:0] {IDLE, CLEAR} stateT;

  stateT             state;
  logic              lastGntB;   // 1 when the most recent grant went to B
  logic [ADDR_W-1:0] clrCnt;     // address currently being cleared
  logic              rvPipe;     // first stage of the read-valid delay
  logic              rvalidA;
  logic              busyR;
  logic              clearDone;
  logic [SEL_W-1:0]  ramSel;
  logic [ADDR_W-1:0] ramMenu;
  logic [ADDR_W-1:0] ramAdd;
  logic [DATA_W-1:0] ramDin;
  logic              ramW;
  logic              gntA;
  logic              gntB;

  // Grant decode: clear request blocks both; ties go to whoever was not granted last
  always_comb begin
    gntA = 1'b0;
    gntB = 1'b0;
    if (!rst && state == IDLE && !bus.clear_req) begin
      if (bus.req_a && (!bus.req_b || lastGntB)) begin
        gntA = 1'b1;
      end else if (bus.req_b) begin
        gntB = 1'b1;
      end
    end
  end

  // Arbiter/clear state machine with registered RAM-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastGntB  <= 1'b0;
      clrCnt    <= '0;
      rvPipe    <= 1'b0;
      rvalidA   <= 1'b0;
      busyR     <= 1'b0;
      clearDone <= 1'b0;
      ramSel    <= '0;
      ramMenu   <= '0;
      ramAdd    <= '0;
      ramDin    <= '0;
      ramW      <= 1'b0;
    end else begin
      // reads already granted keep flowing regardless of a clear starting
      rvPipe    <= gntA;
      rvalidA   <= rvPipe;
      clearDone <= 1'b0;
      case (state)
        IDLE: begin
          ramW <= 1'b0;
          if (bus.clear_req) begin
            state  <= CLEAR;
            clrCnt <= '0;
            busyR  <= 1'b1;
            ramSel <= SEL_LOCAL;
            ramAdd <= '0;
            ramDin <= CLEAR_CHAR;
            ramW   <= 1'b1;
          end else if (gntA) begin
            lastGntB <= 1'b0;
            ramSel   <= bus.sel_a;
            ramMenu  <= bus.menu_a;
            ramAdd   <= bus.add_a;
          end else if (gntB) begin
            lastGntB <= 1'b1;
            ramSel   <= SEL_LOCAL;
            ramAdd   <= bus.add_b;
            ramDin   <= bus.din_b;
            ramW     <= 1'b1;
          end
        end
        CLEAR: begin
          ramSel    <= SEL_LOCAL;
          ramDin    <= CLEAR_CHAR;
          ramW      <= 1'b1;
          // done pulse lines up with the write of the last address
          clearDone <= (clrCnt == PENULT_ADDR);
          if (clrCnt == LAST_ADDR) begin
            state  <= IDLE;
            clrCnt <= '0;
            busyR  <= 1'b0;
            ramW   <= 1'b0;
          end else begin
            clrCnt <= clrCnt + ADDR_W'(1);
            ramAdd <= clrCnt + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_a      = gntA;
  assign bus.gnt_b      = gntB;
  assign bus.rvalid_a   = rvalidA;
  assign bus.rdata_a    = bus.ram_dout;
  assign bus.busy       = busyR;
  assign bus.clear_done = clearDone;
  assign bus.ram_sel    = ramSel;
  assign bus.ram_menu   = ramMenu;
  assign bus.ram_add    = ramAdd;
  assign bus.ram_din    = ramDin;
  assign bus.ram_w      = ramW;
  assign bus.ram_clear  = 1'b0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a behavioural MultiRAM model
// answers the port, and a reference model (expected local RAM contents,
// round-robin rule, expected read queue) predicts every observed value.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_port_arbiter_if bus();
  ram_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [7:0] locMem [32];   // the RAM itself, written only through the port
  logic [7:0] expMem [32];   // reference contents of local RAM
  bit lastB = 1'b0;          // reference: last grant went to B

  function automatic logic [7:0] romByte(input logic [4:0] m, input logic [4:0] a);
    return {m[2:0], a} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] remByte(input logic [4:0] a);
    return 8'hC3 ^ {a, 3'b101};
  endfunction

  function automatic logic [7:0] refRead(input logic [1:0] s, input logic [4:0] m, input logic [4:0] a);
    case (s)
      2'd0:    return romByte(m, a);
      2'd1:    return remByte(a);
      2'd2:    return expMem[a];
      default: return 8'h00;
    endcase
  endfunction

  // MultiRAM: registers write or read data at the end of the access cycle
  always @(posedge clk) begin
    if (bus.ram_w) begin
      if (bus.ram_sel == 2'd2) locMem[bus.ram_add] <= bus.ram_din;
    end else begin
      case (bus.ram_sel)
        2'd0:    bus.ram_dout <= romByte(bus.ram_menu, bus.ram_add);
        2'd1:    bus.ram_dout <= remByte(bus.ram_add);
        2'd2:    bus.ram_dout <= locMem[bus.ram_add];
        default: bus.ram_dout <= 8'h00;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    bus.req_a = 1'b0; bus.sel_a = '0; bus.menu_a = '0; bus.add_a = '0;
    bus.req_b = 1'b0; bus.add_b = '0; bus.din_b = '0; bus.clear_req = 1'b0;
  endtask

  task automatic resetDut();
    idleIn();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    lastB = 1'b0;
  endtask

  task automatic writeLocal(input logic [4:0] a, input logic [7:0] d, output bit g);
    bus.req_b = 1'b1; bus.add_b = a; bus.din_b = d;
    #1; g = bus.gnt_b;
    step();
    bus.req_b = 1'b0;
    expMem[a] = d;
    lastB = 1'b1;
  endtask

  task automatic readLocal(input logic [4:0] a, output logic [7:0] d, output bit ok);
    bit g, v1;
    bus.req_a = 1'b1; bus.sel_a = 2'd2; bus.add_a = a;
    #1; g = bus.gnt_a;
    step();
    bus.req_a = 1'b0;
    v1 = bus.rvalid_a;
    step();
    ok = g && !v1 && bus.rvalid_a;
    d = bus.rdata_a;
    lastB = 1'b0;
  endtask

  task automatic test_reset();
    idleIn();
    rst = 1'b1;
    step(); step();
    checks++; if (bus.ram_sel !== 2'd0) begin failures++; $display("FAIL reset_ram_sel got=%0h exp=0", bus.ram_sel); end
    checks++; if (bus.ram_menu !== 5'd0) begin failures++; $display("FAIL reset_ram_menu got=%0h exp=0", bus.ram_menu); end
    checks++; if (bus.ram_add !== 5'd0) begin failures++; $display("FAIL reset_ram_add got=%0h exp=0", bus.ram_add); end
    checks++; if (bus.ram_din !== 8'd0) begin failures++; $display("FAIL reset_ram_din got=%0h exp=0", bus.ram_din); end
    checks++; if ({bus.ram_w, bus.busy, bus.clear_done, bus.rvalid_a, bus.ram_clear} !== 5'b0)
      begin failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.ram_w, bus.busy, bus.clear_done, bus.rvalid_a, bus.ram_clear}); end
    rst = 1'b0;
    lastB = 1'b0;
  endtask

  task automatic test_single_read();
    bit g;
    int missed = 0;
    for (int i = 0; i < 32; i++) begin
      writeLocal(5'(i), 8'(i), g);
      if (!g) missed++;
    end
    checks++; if (missed != 0) begin failures++; $display("FAIL preset_gnt_b missed=%0d exp=0", missed); end
    step();
    bus.req_a = 1'b1; bus.sel_a = 2'd2; bus.add_a = 5'd5; bus.menu_a = 5'd9;
    #1;
    checks++; if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin failures++; $display("FAIL single_gnt got=%b exp=10", {bus.gnt_a, bus.gnt_b}); end
    step();
    bus.req_a = 1'b0;
    lastB = 1'b0;
    checks++; if ({bus.ram_sel, bus.ram_menu, bus.ram_add, bus.ram_w, bus.rvalid_a} !== {2'd2, 5'd9, 5'd5, 1'b0, 1'b0})
      begin failures++; $display("FAIL single_fields got=%0h exp=%0h", {bus.ram_sel, bus.ram_menu, bus.ram_add, bus.ram_w, bus.rvalid_a}, {2'd2, 5'd9, 5'd5, 1'b0, 1'b0}); end
    step();
    checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'h05)
      begin failures++; $display("FAIL single_rdata got=%b/%0h exp=1/05", bus.rvalid_a, bus.rdata_a); end
  endtask

  task automatic test_tie();
    logic [4:0] ab;
    logic [7:0] db;
    bit expB;
    resetDut();
    for (int i = 0; i < 4; i++) begin
      ab = 5'($urandom); db = 8'($urandom);
      bus.req_a = 1'b1; bus.sel_a = 2'd2; bus.add_a = 5'($urandom);
      bus.req_b = 1'b1; bus.add_b = ab; bus.din_b = db;
      #1;
      expB = (i % 2 == 0);
      checks++; if (bus.gnt_b !== expB || bus.gnt_a !== !expB)
        begin failures++; $display("FAIL tie_order i=%0d got=%b%b exp_b=%b", i, bus.gnt_a, bus.gnt_b, expB); end
      if (expB) expMem[ab] = db;
      step();
      checks++; if (bus.ram_w !== expB) begin failures++; $display("FAIL tie_ram_w i=%0d got=%b exp=%b", i, bus.ram_w, expB); end
      if (expB) begin
        checks++; if ({bus.ram_add, bus.ram_din} !== {ab, db})
          begin failures++; $display("FAIL tie_wr i=%0d got=%0h exp=%0h", i, {bus.ram_add, bus.ram_din}, {ab, db}); end
      end
    end
    idleIn();
    lastB = 1'b0;
    step(); step();
  endtask

  task automatic test_write_then_read();
    bit g, ok;
    logic [7:0] d;
    writeLocal(5'd3, 8'hAA, g);
    checks++; if (!g) begin failures++; $display("FAIL wr_gnt_b got=0 exp=1"); end
    readLocal(5'd3, d, ok);
    checks++; if (!ok || d !== 8'hAA) begin failures++; $display("FAIL wr_rd got=%0h ok=%b exp=aa", d, ok); end
  endtask

  task automatic test_random();
    logic [1:0] eSel = '0;
    logic [4:0] eMenu = '0, eAdd = '0;
    logic [7:0] eDin = '0;
    bit eW = 1'b0;
    bit pa = 1'b0, pb = 1'b0, ga, gb, expRv;
    logic [1:0] sa;
    logic [4:0] ma, aa, ab;
    logic [7:0] db;
    int dueQ[$];
    logic [7:0] datQ[$];
    bit skipQ[$];
    resetDut();
    for (int c = 0; c < 400; c++) begin
      expRv = (dueQ.size() != 0) && (dueQ[0] == c);
      checks++; if (bus.rvalid_a !== expRv) begin failures++; $display("FAIL rand_rvalid c=%0d got=%b exp=%b", c, bus.rvalid_a, expRv); end
      if (expRv) begin
        if (!skipQ[0]) begin
          checks++; if (bus.rdata_a !== datQ[0]) begin failures++; $display("FAIL rand_rdata c=%0d got=%0h exp=%0h", c, bus.rdata_a, datQ[0]); end
        end
        void'(dueQ.pop_front()); void'(datQ.pop_front()); void'(skipQ.pop_front());
      end
      checks++; if ({bus.ram_sel, bus.ram_menu, bus.ram_add, bus.ram_din, bus.ram_w} !== {eSel, eMenu, eAdd, eDin, eW})
        begin failures++; $display("FAIL rand_ram c=%0d got=%0h exp=%0h", c, {bus.ram_sel, bus.ram_menu, bus.ram_add, bus.ram_din, bus.ram_w}, {eSel, eMenu, eAdd, eDin, eW}); end
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; sa = 2'($urandom); ma = 5'($urandom); aa = 5'($urandom);
      end
      if (!pb && $urandom_range(0, 1) == 1) begin
        pb = 1'b1; ab = 5'($urandom); db = 8'($urandom);
      end
      bus.req_a = pa; bus.sel_a = sa; bus.menu_a = ma; bus.add_a = aa;
      bus.req_b = pb; bus.add_b = ab; bus.din_b = db;
      #1;
      ga = pa && (!pb || lastB);
      gb = pb && (!pa || !lastB);
      checks++; if ({bus.gnt_a, bus.gnt_b} !== {ga, gb}) begin failures++; $display("FAIL rand_gnt c=%0d got=%b%b exp=%b%b", c, bus.gnt_a, bus.gnt_b, ga, gb); end
      eW = 1'b0;
      if (ga) begin
        eSel = sa; eMenu = ma; eAdd = aa;
        dueQ.push_back(c + 2); datQ.push_back(refRead(sa, ma, aa)); skipQ.push_back(sa == 2'd3);
        pa = 1'b0; lastB = 1'b0;
      end
      if (gb) begin
        eSel = 2'd2; eAdd = ab; eDin = db; eW = 1'b1;
        expMem[ab] = db;
        pb = 1'b0; lastB = 1'b1;
      end
      step();
    end
    idleIn();
    step(); step(); step();
  endtask

  task automatic test_clear();
    logic [7:0] d, remExp;
    logic [4:0] a;
    bit ok;
    int doneCnt = 0;
    // a read granted the cycle before the clear request
    bus.req_a = 1'b1; bus.sel_a = 2'd1; bus.menu_a = '0; bus.add_a = 5'd7;
    remExp = remByte(5'd7);
    #1;
    checks++; if (bus.gnt_a !== 1'b1) begin failures++; $display("FAIL clr_pre_gnt got=%b exp=1", bus.gnt_a); end
    lastB = 1'b0;
    step();
    bus.sel_a = 2'd2; bus.add_a = 5'd3; bus.clear_req = 1'b1;
    #1;
    checks++; if ({bus.gnt_a, bus.gnt_b} !== 2'b00) begin failures++; $display("FAIL clr_req_gnt got=%b exp=00", {bus.gnt_a, bus.gnt_b}); end
    step();
    bus.clear_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checks++; if ({bus.ram_w, bus.ram_sel, bus.ram_add, bus.ram_din, bus.busy} !== {1'b1, 2'd2, 5'(k), 8'h20, 1'b1})
        begin failures++; $display("FAIL clr_write k=%0d got=%0h exp=%0h", k, {bus.ram_w, bus.ram_sel, bus.ram_add, bus.ram_din, bus.busy}, {1'b1, 2'd2, 5'(k), 8'h20, 1'b1}); end
      checks++; if (bus.clear_done !== (k == 31)) begin failures++; $display("FAIL clr_done k=%0d got=%b exp=%b", k, bus.clear_done, (k == 31)); end
      if (bus.clear_done) doneCnt++;
      if (k == 0) begin
        checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== remExp)
          begin failures++; $display("FAIL clr_inflight got=%b/%0h exp=1/%0h", bus.rvalid_a, bus.rdata_a, remExp); end
      end
      bus.req_b = (k >= 4 && k < 20); bus.add_b = 5'($urandom); bus.din_b = 8'($urandom);
      bus.clear_req = (k == 9);
      #1;
      checks++; if ({bus.gnt_a, bus.gnt_b} !== 2'b00) begin failures++; $display("FAIL clr_blocked k=%0d got=%b exp=00", k, {bus.gnt_a, bus.gnt_b}); end
      step();
    end
    bus.clear_req = 1'b0; bus.req_b = 1'b0;
    checks++; if ({bus.busy, bus.ram_w, bus.clear_done} !== 3'b000)
      begin failures++; $display("FAIL clr_end got=%b exp=000", {bus.busy, bus.ram_w, bus.clear_done}); end
    #1;
    checks++; if (bus.gnt_a !== 1'b1) begin failures++; $display("FAIL clr_post_gnt got=%b exp=1", bus.gnt_a); end
    lastB = 1'b0;
    step();
    bus.req_a = 1'b0;
    step();
    checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'h20)
      begin failures++; $display("FAIL clr_post_rd got=%b/%0h exp=1/20", bus.rvalid_a, bus.rdata_a); end
    for (int i = 0; i < 4; i++) begin
      if (bus.clear_done) doneCnt++;
      step();
    end
    checks++; if (doneCnt != 1) begin failures++; $display("FAIL clr_done_count got=%0d exp=1", doneCnt); end
    for (int i = 0; i < 32; i++) expMem[i] = 8'h20;
    for (int i = 0; i < 6; i++) begin
      a = 5'($urandom);
      readLocal(a, d, ok);
      checks++; if (!ok || d !== 8'h20) begin failures++; $display("FAIL clr_readback a=%0d got=%0h ok=%b exp=20", a, d, ok); end
    end
  endtask

  task automatic test_reset_mid_clear();
    bit g, ok;
    bit sawDone = 1'b0;
    logic [7:0] d;
    int missed = 0;
    for (int i = 0; i < 32; i++) begin
      writeLocal(5'(i), 8'(i) ^ 8'hA5, g);
      if (!g) missed++;
    end
    checks++; if (missed != 0) begin failures++; $display("FAIL rmc_preset missed=%0d exp=0", missed); end
    step();
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if ({bus.ram_w, bus.ram_add} !== {1'b1, 5'(k)})
        begin failures++; $display("FAIL rmc_write k=%0d got=%0h exp=%0h", k, {bus.ram_w, bus.ram_add}, {1'b1, 5'(k)}); end
      if (bus.clear_done) sawDone = 1'b1;
      if (k == 9) rst = 1'b1;
      step();
    end
    checks++; if ({bus.ram_sel, bus.ram_menu, bus.ram_add, bus.ram_din, bus.ram_w, bus.busy, bus.clear_done, bus.rvalid_a} !== 25'd0)
      begin failures++; $display("FAIL rmc_outputs got=%0h exp=0", {bus.ram_sel, bus.ram_menu, bus.ram_add, bus.ram_din, bus.ram_w, bus.busy, bus.clear_done, bus.rvalid_a}); end
    rst = 1'b0;
    lastB = 1'b0;
    for (int i = 0; i < 10; i++) expMem[i] = 8'h20;
    for (int i = 0; i < 4; i++) begin
      if (bus.clear_done) sawDone = 1'b1;
      step();
    end
    checks++; if (sawDone) begin failures++; $display("FAIL rmc_no_done got=1 exp=0"); end
    for (int i = 0; i < 16; i++) begin
      readLocal(5'(i), d, ok);
      checks++; if (!ok || d !== expMem[i]) begin failures++; $display("FAIL rmc_readback a=%0d got=%0h ok=%b exp=%0h", i, d, ok, expMem[i]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idleIn();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_tie();
    test_write_then_read();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
